// File: rtl/icache_fill_ctrl.sv
// Direct-mapped instruction cache with a block-fill controller for a 128-bit block-read memory.
// Optional hit/miss statistics counters are enabled by defining ICACHE_STATS_EN.
module icache_fill_ctrl #(
  parameter int unsigned NUM_SETS = 8,
  parameter int unsigned ADDR_W   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_read,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              flush,
  output logic [31:0]       instruction,
  output logic              cpu_busywait,
  output logic              mem_read,
  output logic [27:0]       mem_address,
  input  logic [127:0]      mem_readdata,
  input  logic              mem_busywait
`ifdef ICACHE_STATS_EN
  ,
  output logic [31:0]       hit_count,
  output logic [31:0]       miss_count
`endif
);

  localparam int unsigned INDEX_W = $clog2(NUM_SETS);
  localparam int unsigned BLK_W   = ADDR_W - 4;
  localparam int unsigned TAG_W   = ADDR_W - 4 - INDEX_W;
  localparam int unsigned LINE_W  = 128;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [NUM_SETS-1:0] valid_q;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [LINE_W-1:0]   data_q [NUM_SETS];
  logic [BLK_W-1:0]    fill_blk_q;

  logic [INDEX_W-1:0]  cur_index;
  logic [TAG_W-1:0]    cur_tag;
  logic [1:0]          cur_word;
  logic [INDEX_W-1:0]  fill_index;
  logic [TAG_W-1:0]    fill_tag;

  logic                hit;
  logic                start_fill;
  logic                capture;
  logic                commit;
  logic                flush_en;
  logic                unused_ok;

  // Address decomposition; byte-within-word bits play no part in an instruction fetch.
  assign cur_index  = cpu_address[4 +: INDEX_W];
  assign cur_tag    = cpu_address[ADDR_W-1 -: TAG_W];
  assign cur_word   = cpu_address[3:2];
  assign fill_index = fill_blk_q[INDEX_W-1:0];
  assign fill_tag   = fill_blk_q[BLK_W-1 -: TAG_W];
  assign unused_ok  = &{1'b0, cpu_address[1:0]};

  // Lookup is only trusted in IDLE; during a fill the line under update may be inconsistent.
  assign hit = cpu_read & valid_q[cur_index] & (tag_q[cur_index] == cur_tag) & (state_q == IDLE);

  assign cpu_busywait = (state_q != IDLE) | (cpu_read & ~hit);
  assign mem_address  = 28'(fill_blk_q);

  always_comb begin
    instruction = 32'h0;
    if (hit) begin
      instruction = data_q[cur_index][{cur_word, 5'd0} +: 32];
    end
  end

  // Next-state and control decode.
  always_comb begin
    state_d    = state_q;
    start_fill = 1'b0;
    capture    = 1'b0;
    commit     = 1'b0;
    flush_en   = 1'b0;
    case (state_q)
      IDLE: begin
        flush_en = flush;
        if (cpu_read && !hit) begin
          start_fill = 1'b1;
          state_d    = MEM_READ;
        end
      end
      MEM_READ: begin
        if (!mem_busywait) begin
          capture = 1'b1;
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State, request and line-valid registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      mem_read   <= 1'b0;
      fill_blk_q <= '0;
      valid_q    <= '0;
    end else begin
      state_q  <= state_d;
      mem_read <= (state_d == MEM_READ);
      if (start_fill) begin
        fill_blk_q <= cpu_address[ADDR_W-1:4];
      end
      if (flush_en) begin
        valid_q <= '0;
      end
      if (commit) begin
        valid_q[fill_index] <= 1'b1;
      end
    end
  end

  // Line storage; contents are meaningless until the matching valid bit is set.
  always_ff @(posedge clock) begin
    if (capture) begin
      data_q[fill_index] <= mem_readdata;
    end
    if (commit) begin
      tag_q[fill_index] <= fill_tag;
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating hit/miss counters, untouched by flush.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      if (hit && (hit_count != 32'hFFFF_FFFF)) begin
        hit_count <= hit_count + 32'd1;
      end
      if (start_fill && (miss_count != 32'hFFFF_FFFF)) begin
        miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Self-checking bench for icache_fill_ctrl: directed scenarios then random fetch/flush traffic
// against a set-resident-block model and an address-derived memory image.
module tb_icache_fill_ctrl;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         cpu_read = 1'b0;
  logic [31:0]  cpu_address = 32'h0;
  logic         flush = 1'b0;
  logic [31:0]  instruction;
  logic         cpu_busywait;
  logic         mem_read;
  logic [27:0]  mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
`ifdef ICACHE_STATS_EN
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;
`endif

  icache_fill_ctrl dut (
    .clock        (clock),
    .reset        (reset),
    .cpu_read     (cpu_read),
    .cpu_address  (cpu_address),
    .flush        (flush),
    .instruction  (instruction),
    .cpu_busywait (cpu_busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readdata (mem_readdata),
    .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int lat   = 16;
  int cnt   = 0;

  // Model state: which block each set holds, plus expected statistics.
  bit          mv [8];
  logic [27:0] mb [8];
  int          exp_hits   = 0;
  int          exp_misses = 0;

  function automatic logic [7:0] mbyte(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ a[31:24];
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] addr);
    logic [31:0] a;
    a = {addr[31:2], 2'b00};
    return {mbyte(a + 32'd3), mbyte(a + 32'd2), mbyte(a + 32'd1), mbyte(a)};
  endfunction

  // Memory: busy for lat cycles of a request, then presents the block.
  always @(posedge clock) cnt <= mem_read ? cnt + 1 : 0;
  assign mem_busywait = mem_read && (cnt < lat);
  always_comb begin
    for (int k = 0; k < 16; k++) begin
      mem_readdata[8*k +: 8] = mbyte({mem_address, 4'(k)});
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 8; i++) mv[i] = 1'b0;
  endtask

  task automatic fetch(input logic [31:0] addr, input bit fl);
    bit model_hit;
    int n;
    int idx;
    idx = int'(addr[6:4]);
    @(negedge clock);
    cpu_read    = 1'b1;
    cpu_address = addr;
    flush       = fl;
    #1;
    model_hit = mv[idx] && (mb[idx] == addr[31:4]);
    if (model_hit) begin
      check("hit_busywait", 128'(cpu_busywait), 128'(0));
      check("hit_instr", 128'(instruction), 128'(exp_word(addr)));
      check("hit_no_memread", 128'(mem_read), 128'(0));
      @(posedge clock);
      #1;
      flush = 1'b0;
      exp_hits++;
      if (fl) model_clear();
    end else begin
      check("miss_busywait", 128'(cpu_busywait), 128'(1));
      check("miss_instr_zero", 128'(instruction), 128'(0));
      @(posedge clock);
      #1;
      flush = 1'b0;
      exp_misses++;
      if (fl) model_clear();
      check("miss_memread", 128'(mem_read), 128'(1));
      check("miss_memaddr", 128'(mem_address), 128'(addr[31:4]));
      n = 1;
      for (int b = 0; b < 200 && cpu_busywait; b++) begin
        n++;
        @(posedge clock);
        #1;
      end
      check("miss_stall_cycles", 128'(n), 128'(lat + 3));
      check("refill_instr", 128'(instruction), 128'(exp_word(addr)));
      check("refill_no_memread", 128'(mem_read), 128'(0));
      mv[idx] = 1'b1;
      mb[idx] = addr[31:4];
      @(posedge clock);
      #1;
      exp_hits++;
    end
    cpu_read = 1'b0;
  endtask

  task automatic flush_pulse();
    @(negedge clock);
    cpu_read = 1'b0;
    flush    = 1'b1;
    #1;
    check("flush_busywait", 128'(cpu_busywait), 128'(0));
    @(posedge clock);
    #1;
    flush = 1'b0;
    model_clear();
  endtask

  task automatic check_stats(input string tag);
`ifdef ICACHE_STATS_EN
    check({tag, "_hits"}, 128'(hit_count), 128'(exp_hits));
    check({tag, "_misses"}, 128'(miss_count), 128'(exp_misses));
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] a;
    logic [31:0] tags [4];
    model_clear();

    // Reset state
    #2;
    check("rst_memread", 128'(mem_read), 128'(0));
    check("rst_memaddr", 128'(mem_address), 128'(0));
    check("rst_busywait", 128'(cpu_busywait), 128'(0));
    check("rst_instr", 128'(instruction), 128'(0));
    repeat (2) @(negedge clock);
    reset = 1'b1;
    check_stats("rst");

    // Cold miss then sequential hits in the same block
    lat = 16;
    fetch(32'h0000_0000, 1'b0);
    fetch(32'h0000_0004, 1'b0);
    fetch(32'h0000_0008, 1'b0);
    fetch(32'h0000_000C, 1'b0);
    check_stats("cold");
    check("cold_instr_val", 128'(exp_word(32'h0)), 128'(32'h0302_0100));

    // Conflict in set 0
    lat = 3;
    fetch(32'h0000_0080, 1'b0);
    fetch(32'h0000_0000, 1'b0);

    // Flush after lines are filled
    fetch(32'h0000_0010, 1'b0);
    flush_pulse();
    fetch(32'h0000_0004, 1'b0);

    // Reset in the middle of a fill
    lat = 10;
    @(negedge clock);
    cpu_read    = 1'b1;
    cpu_address = 32'h0000_0100;
    @(posedge clock);
    #1;
    check("pre_rst_memread", 128'(mem_read), 128'(1));
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("midfill_rst_memread", 128'(mem_read), 128'(0));
    check("midfill_rst_memaddr", 128'(mem_address), 128'(0));
    cpu_read = 1'b0;
    #1;
    check("midfill_rst_busywait", 128'(cpu_busywait), 128'(0));
    check("midfill_rst_instr", 128'(instruction), 128'(0));
    model_clear();
    exp_hits   = 0;
    exp_misses = 0;
    check_stats("midfill_rst");
    @(negedge clock);
    reset = 1'b1;
    lat = 2;
    fetch(32'h0000_0000, 1'b0);

    // Random traffic, including flush coincident with fetches
    tags[0] = 32'h0;
    tags[1] = 32'h1;
    tags[2] = 32'h2;
    tags[3] = 32'h1ABC_DE;
    for (int it = 0; it < 150; it++) begin
      lat = int'($urandom_range(0, 4));
      a = (tags[$urandom_range(0, 3)] << 7) | 32'($urandom_range(0, 127));
      if ($urandom_range(0, 19) == 0) flush_pulse();
      fetch(a, $urandom_range(0, 9) == 0);
    end
    check_stats("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/icache_fill_ctrl.md
Name: icache_fill_ctrl

Overview:
- Direct-mapped instruction cache and controller on the CPU fetch path.
- It is the initiator of the 128-bit block-read protocol served by the instruction memory:
  - asserts mem_read with a 28-bit block address;
  - waits while mem_busywait is high;
  - captures the 16-byte block when mem_busywait falls.
- It returns a 32-bit instruction to the pipeline and stalls the pipeline with cpu_busywait on a miss.

Parameters:
- NUM_SETS, 8, number of cache lines (power of 2, minimum 2); INDEX_W = log2(NUM_SETS).
- ADDR_W, 32, CPU byte-address width; TAG_W = ADDR_W - 4 - INDEX_W.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- cpu_read  input  1  fetch request from the pipeline.
- cpu_address  input  ADDR_W  byte address of the fetch (PC).
- flush  input  1  invalidate all lines.
- instruction  output  32  fetched instruction word.
- cpu_busywait  output  1  pipeline stall.
- mem_read  output  1  block-read request to instruction memory.
- mem_address  output  28  block address, equal to cpu_address[31:4].
- mem_readdata  input  128  returned block; byte k is at bits [8k+7:8k].
- mem_busywait  input  1  memory busy; the block is valid when it is 0 while mem_read=1.

Behaviour:
- Address split: offset = addr[3:0]; word select = addr[3:2]; index = addr[4+INDEX_W-1:4]; tag = upper TAG_W bits.
- Storage: per line, a valid bit, a tag and 128 data bits.
- Hit (combinational) = cpu_read & valid[index] & (tag match) & state==IDLE.
  - On hit: instruction = data[index][32*w+31:32*w], where w = word select.
  - When there is no hit: instruction = 32'h0.
- cpu_busywait (combinational) = (state==IDLE & cpu_read & !hit) | state!=IDLE.
- Alignment: cpu_address[1:0] is ignored.
- FSM, states IDLE, MEM_READ, UPDATE:
  - IDLE: on cpu_read & miss, latch the block address and go to MEM_READ. Otherwise stay.
  - MEM_READ:
    - Outputs: mem_read=1, mem_address = latched block address.
    - Stay while mem_busywait=1.
    - On the first rising edge where mem_busywait=0: capture mem_readdata into the line and go to UPDATE.
  - UPDATE:
    - mem_read=0.
    - Write tag and set valid for the latched index.
    - Go to IDLE; the retried fetch then hits in the following cycle.
- Miss penalty: 1 cycle (detect) + memory cycles + 1 cycle (UPDATE).
- cpu_address changes during MEM_READ/UPDATE are ignored; the fill uses the latched address.
- mem_read is deasserted for at least one cycle between consecutive fills, so memory can re-arm its request detection.
- flush:
  - Honoured only in IDLE: all valid bits clear at the clock edge, and the same-cycle lookup is still evaluated against the pre-flush state.
  - Ignored in MEM_READ/UPDATE; the caller holds flush until cpu_busywait=0.
- Reset (reset=0, asynchronous, including mid-fill):
  - state=IDLE; all valid=0; mem_read=0; mem_address=0.
  - cpu_busywait and instruction resolve to 0 while cpu_read=0.
  - Any fill in progress is abandoned and nothing is written.
- Simultaneous miss and flush in IDLE: the flush takes effect and the miss fill starts.

Optional Feature:
- Macro ICACHE_STATS_EN.
- When defined, adds outputs hit_count[31:0] and miss_count[31:0]:
  - hit_count increments once per cycle in which hit=1;
  - miss_count increments on each IDLE to MEM_READ transition;
  - both saturate at 32'hFFFF_FFFF;
  - both clear on reset;
  - neither is affected by flush.
- When undefined: no counters and no extra ports; the rest of the behaviour is identical.

Test Plan:
- Cold miss at 0x0000_0000, memory holding bytes 0x00..0x0F, with 16-cycle busywait:
  - mem_read=1 and mem_address=28'h0 the cycle after the request;
  - after mem_busywait falls: UPDATE, then hit;
  - instruction=32'h03020100, with cpu_busywait low.
- Following fetches 0x4, 0x8, 0xC: hit in the same cycle with no mem_read; instruction=32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C.
- Conflict: fetch 0x80 (index 0 with NUM_SETS=8): miss and refill with mem_address=28'h8. A subsequent fetch of 0x0 misses again.
- Reset driven low in the middle of MEM_READ:
  - mem_read drops immediately;
  - after release, a fetch of 0x0 misses (valid was cleared).
- flush pulse in IDLE after lines are filled: the next fetch of 0x4 misses and issues mem_read.
- With ICACHE_STATS_EN: scenarios 1 and 2 combined yield miss_count=1 and hit_count=4.
